// File: rtl/ternary_nn_pkg.sv
// Shared definitions for the ternary neuron: weight-pair layout, FSM states
// and the width helpers used to size the datapath from N_IN and N_BEATS.
package ternary_nn_pkg;

  // Bit positions inside one 2-bit weight pair {sign, zero}
  localparam int ZERO_BIT = 0;
  localparam int SIGN_BIT = 1;
  localparam int PAIR_W   = 2;

  // Neuron sequencing: accumulate beats, then present one result
  typedef enum logic [0:0] {
    ACC = 1'b0,
    OUT = 1'b1
  } neuron_state_e;

  // Signed width holding +/- n_in*n_beats without overflow
  function automatic int acc_width(input int n_in, input int n_beats);
    return $clog2(n_in * n_beats) + 2;
  endfunction

  // Signed width holding one beat's dot product (+/- n_in)
  function automatic int dot_width(input int n_in);
    return $clog2(n_in) + 2;
  endfunction

endpackage

// File: rtl/ternary_dot.sv
// Combinational single-beat ternary dot product: N_IN binary activations
// against N_IN {sign, zero} weight pairs, summed into a signed result.
module ternary_dot
  import ternary_nn_pkg::*;
#(
  parameter int N_IN  = 8,
  parameter int DOT_W = dot_width(N_IN)
) (
  input  logic [N_IN-1:0]        x,
  input  logic [PAIR_W*N_IN-1:0] w,
  output logic signed [DOT_W-1:0] dot
);

  localparam logic signed [DOT_W-1:0] ONE = DOT_W'(1);

  logic signed [DOT_W-1:0] sum_v;

  // Each lane contributes +1, -1 or 0; an idle activation or a zero weight contributes nothing
  always_comb begin
    sum_v = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (x[i] && !w[PAIR_W*i + ZERO_BIT]) begin
        if (w[PAIR_W*i + SIGN_BIT]) begin
          sum_v = sum_v - ONE;
        end else begin
          sum_v = sum_v + ONE;
        end
      end
    end
    dot = sum_v;
  end

endmodule

// File: rtl/ternary_neuron_seq.sv
// Sequential ternary neuron: bit-serial weight loading, N_BEATS accumulated
// beats of N_IN synapses, optional ReLU, threshold compare and a
// valid/ready result port.
module ternary_neuron_seq
  import ternary_nn_pkg::*;
#(
  parameter int N_IN    = 8,
  parameter int N_BEATS = 4,
  parameter int RELU    = 0,
  parameter int ACC_W   = acc_width(N_IN, N_BEATS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wt_load_en,
  input  logic                    wt_bit,
  output logic                    wt_ready,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [N_IN-1:0]         x,
  input  logic signed [ACC_W-1:0] threshold,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [ACC_W-1:0] out_sum,
  output logic                    out_act
);

  localparam int SLICE_W = PAIR_W * N_IN;
  localparam int W_BITS  = SLICE_W * N_BEATS;
  localparam int DOT_W   = dot_width(N_IN);
  localparam int BEAT_W  = (N_BEATS > 1) ? $clog2(N_BEATS) : 1;
  localparam int CNT_W   = $clog2(W_BITS + 1);

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(N_BEATS - 1);
  localparam logic [CNT_W-1:0]  WT_TOTAL  = CNT_W'(W_BITS);

  neuron_state_e            state;
  logic [W_BITS-1:0]        w_reg;
  logic [CNT_W-1:0]         wt_cnt;
  logic [BEAT_W-1:0]        beat_cnt;
  logic signed [ACC_W-1:0]  acc;
  logic [SLICE_W-1:0]       slice;
  logic signed [DOT_W-1:0]  dot;
  logic signed [ACC_W-1:0]  beat_sum;
  logic signed [ACC_W-1:0]  final_sum;
  logic                     wt_accept;
  logic                     beat_fire;

  // Loading is only allowed between results, before the first beat of a new sum
  always_comb begin
    wt_accept = wt_load_en && (state == ACC) && (beat_cnt == '0);
  end

  // A beat-0 load request blocks the input so the weights never change under a sum
  always_comb begin
    in_ready  = wt_ready && (state == ACC) && !((beat_cnt == '0) && wt_load_en);
    beat_fire = in_valid && in_ready;
  end

  // Serial weight shifter; holds no reset value because a full reload is always required
  always_ff @(posedge clk) begin
    if (!rst && wt_accept) begin
      w_reg <= {w_reg[W_BITS-2:0], wt_bit};
    end
  end

  // Count loaded bits, saturate when full, and restart on a reload of a ready register
  always_ff @(posedge clk) begin
    if (rst) begin
      wt_cnt   <= '0;
      wt_ready <= 1'b0;
    end else if (wt_accept) begin
      if (wt_ready) begin
        wt_cnt   <= CNT_W'(1);
        wt_ready <= 1'b0;
      end else begin
        wt_cnt   <= wt_cnt + CNT_W'(1);
        wt_ready <= (wt_cnt == WT_TOTAL - CNT_W'(1));
      end
    end
  end

  // Pick the weight slice belonging to the current beat
  always_comb begin
    slice = w_reg[int'(beat_cnt)*SLICE_W +: SLICE_W];
  end

  ternary_dot #(
    .N_IN  (N_IN),
    .DOT_W (DOT_W)
  ) u_dot (
    .x   (x),
    .w   (slice),
    .dot (dot)
  );

  // Running sum including this beat, and its ReLU-clamped form for the last beat
  always_comb begin
    beat_sum  = acc + ACC_W'(dot);
    final_sum = beat_sum;
    if ((RELU != 0) && beat_sum[ACC_W-1]) begin
      final_sum = '0;
    end
  end

  // Accumulate beats, then hold the registered result until the consumer takes it
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ACC;
      acc       <= '0;
      beat_cnt  <= '0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_act   <= 1'b0;
    end else begin
      case (state)
        ACC: begin
          if (beat_fire) begin
            if (beat_cnt == LAST_BEAT) begin
              out_sum   <= final_sum;
              out_act   <= (final_sum > threshold);
              out_valid <= 1'b1;
              state     <= OUT;
              acc       <= '0;
              beat_cnt  <= '0;
            end else begin
              acc      <= beat_sum;
              beat_cnt <= beat_cnt + BEAT_W'(1);
            end
          end
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= ACC;
          end
        end
        default: begin
          state     <= ACC;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
